// File: rtl/result_sram_reader_pkg.sv
// Shared widths, FSM state codes and coordinate helper for the ResultSRAM read path.
package result_sram_reader_pkg;

    localparam int RD_DATA_W  = 8;
    localparam int RD_COORD_W = 7;
    localparam int RD_ADDR_W  = 14;
    localparam int RD_DIM_W   = 6;

    localparam logic [1:0] RD_IDLE  = 2'd0;
    localparam logic [1:0] RD_ISSUE = 2'd1;
    localparam logic [1:0] RD_DRAIN = 2'd2;
    localparam logic [1:0] RD_FIN   = 2'd3;

    // True when coord is the final index of a dimension of size dim (dim >= 1).
    function automatic logic is_last(input logic [RD_COORD_W-1:0] coord,
                                     input logic [RD_DIM_W-1:0]   dim);
        return coord == (RD_COORD_W'(dim) - RD_COORD_W'(1'b1));
    endfunction

endpackage

// File: rtl/result_sram_reader_fifo.sv
// Two-entry pixel skid FIFO that catches SRAM read data while the consumer stalls.
module pix_skid_fifo #(
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [1:0]        count,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] mem_r [0:1];
    logic              wr_ptr_r;
    logic              rd_ptr_r;
    logic [1:0]        count_r;

    // Storage, pointers and occupancy; push and pop in one cycle leave count unchanged.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            mem_r[0] <= {DATA_W{1'b0}};
            mem_r[1] <= {DATA_W{1'b0}};
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_r + {1'b0, push} - {1'b0, pop};
        end
    end

    assign count = count_r;
    assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/result_sram_reader.sv
// Streams a TW x TH resized image out of ResultSRAM in raster order over valid/ready.
module result_sram_reader
    import result_sram_reader_pkg::*;
#(
    parameter int DATA_W  = RD_DATA_W,
    parameter int COORD_W = RD_COORD_W,
    parameter int ADDR_W  = RD_ADDR_W
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    input  logic [RD_DIM_W-1:0] TW,
    input  logic [RD_DIM_W-1:0] TH,
    output logic                sram_cen,
    output logic [ADDR_W-1:0]   sram_addr,
    input  logic [DATA_W-1:0]   sram_q,
    output logic [DATA_W-1:0]   out_val,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                done
);

    logic [1:0]          state_r;
    logic [1:0]          state_nxt_s;
    logic [RD_DIM_W-1:0] tw_r;
    logic [RD_DIM_W-1:0] th_r;
    logic [COORD_W-1:0]  row_r;
    logic [COORD_W-1:0]  col_r;
    logic                inflight_r;
    logic                fin_seen_r;
    logic [ADDR_W-1:0]   addr_hold_r;
    logic [1:0]          fifo_count_s;
    logic [DATA_W-1:0]   fifo_head_s;
    logic [2:0]          outstanding_s;
    logic                pop_s;
    logic                issue_s;
    logic                last_col_s;
    logic                last_row_s;
    logic                last_pop_s;

    pix_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (inflight_r),
        .pop   (pop_s),
        .din   (sram_q),
        .count (fifo_count_s),
        .head  (fifo_head_s)
    );

    assign out_valid = (fifo_count_s != 2'd0);
    assign out_val   = fifo_head_s;
    assign pop_s     = out_valid & out_ready;

    // Pixels owed after this cycle's pop; counting the pop keeps 1 pixel/cycle with 2 entries.
    assign outstanding_s = {1'b0, fifo_count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
    assign issue_s       = (state_r == RD_ISSUE) && (outstanding_s < 3'd2);
    assign last_col_s    = is_last(col_r, tw_r);
    assign last_row_s    = is_last(row_r, th_r);
    assign last_pop_s    = (state_r == RD_DRAIN) && pop_s && (outstanding_s == 3'd0);

    assign sram_cen  = ~issue_s;
    assign sram_addr = issue_s ? {row_r, col_r} : addr_hold_r;
    assign busy      = (state_r != RD_IDLE);
    assign done      = last_pop_s | ((state_r == RD_FIN) && fin_seen_r);

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            RD_IDLE: begin
                if (start) begin
                    if ((TW == {RD_DIM_W{1'b0}}) || (TH == {RD_DIM_W{1'b0}})) begin
                        state_nxt_s = RD_FIN;
                    end else begin
                        state_nxt_s = RD_ISSUE;
                    end
                end else begin
                    state_nxt_s = RD_IDLE;
                end
            end
            RD_ISSUE: begin
                if (issue_s && last_col_s && last_row_s) begin
                    state_nxt_s = RD_DRAIN;
                end else begin
                    state_nxt_s = RD_ISSUE;
                end
            end
            RD_DRAIN: begin
                if (last_pop_s) begin
                    state_nxt_s = RD_IDLE;
                end else begin
                    state_nxt_s = RD_DRAIN;
                end
            end
            RD_FIN: begin
                if (fin_seen_r) begin
                    state_nxt_s = RD_IDLE;
                end else begin
                    state_nxt_s = RD_FIN;
                end
            end
            default: state_nxt_s = RD_IDLE;
        endcase
    end

    // State, frame geometry, raster counters and read-pipeline tracking.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r     <= RD_IDLE;
            tw_r        <= {RD_DIM_W{1'b0}};
            th_r        <= {RD_DIM_W{1'b0}};
            row_r       <= {COORD_W{1'b0}};
            col_r       <= {COORD_W{1'b0}};
            inflight_r  <= 1'b0;
            fin_seen_r  <= 1'b0;
            addr_hold_r <= {ADDR_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            inflight_r  <= issue_s;
            addr_hold_r <= sram_addr;
            // Empty frames sit in FIN for two cycles so done lands one cycle after entry.
            fin_seen_r  <= (state_r == RD_FIN) && !fin_seen_r;
            if ((state_r == RD_IDLE) && start) begin
                tw_r  <= TW;
                th_r  <= TH;
                row_r <= {COORD_W{1'b0}};
                col_r <= {COORD_W{1'b0}};
            end else if (issue_s) begin
                col_r <= last_col_s ? {COORD_W{1'b0}} : col_r + {{(COORD_W-1){1'b0}}, 1'b1};
                if (last_col_s && !last_row_s) begin
                    row_r <= row_r + {{(COORD_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

endmodule

// File: tb/tb_result_sram_reader.sv
// Self-checking bench: SRAM model plus a raster-order pixel queue as the reference.
module tb_result_sram_reader;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  TW = 6'd0;
    logic [5:0]  TH = 6'd0;
    logic        sram_cen;
    logic [13:0] sram_addr;
    logic [7:0]  sram_q = 8'd0;
    logic [7:0]  out_val;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        done;

    int vectors = 0;
    int miscompares = 0;

    result_sram_reader dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .TW        (TW),
        .TH        (TH),
        .sram_cen  (sram_cen),
        .sram_addr (sram_addr),
        .sram_q    (sram_q),
        .out_val   (out_val),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] pix(input int r, input int c);
        return 8'((r * 16 + c) & 255);
    endfunction

    // ResultSRAM: one-cycle read latency
    always @(posedge CLK) begin
        if (sram_cen == 1'b0) sram_q <= pix(int'(sram_addr[13:7]), int'(sram_addr[6:0]));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_cen"},       32'(sram_cen),  32'd1);
        chk({tag, "_addr"},      32'(sram_addr), 32'd0);
        chk({tag, "_out_val"},   32'(out_val),   32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_done"},      32'(done),      32'd0);
    endtask

    // mode: 0 ready held high, 1 ready pattern 1,0,0 repeating, 2 random ready
    task automatic run_frame(input int tw, input int th, input int mode,
                             input int abort_after, input bit restart);
        logic [7:0] exp_q[$];
        int   total = tw * th;
        int   issued = 0;
        int   accepted = 0;
        int   cyc = 0;
        int   first_valid = -1;
        int   max_row = 0;
        bit   done_seen = 1'b0;
        bit   prev_stall = 1'b0;
        bit   finished = 1'b0;
        bit   exp_done;
        logic [7:0] prev_d = 8'd0;
        logic [7:0] last_pix = 8'd0;

        for (int r = 0; r < th; r++)
            for (int c = 0; c < tw; c++)
                exp_q.push_back(pix(r, c));

        @(posedge CLK); #1;
        start = 1'b1; TW = 6'(tw); TH = 6'(th); out_ready = 1'b1;
        while (!finished && cyc < 10000) begin
            @(posedge CLK); #1;
            cyc++;
            start = restart && (cyc == 4 || cyc == total + 2);
            if (start) begin TW = 6'd7; TH = 6'd9; end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 1);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge CLK);
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_val",   32'(out_val),   32'(prev_d));
            end
            if (done_seen) begin
                chk("busy_after_done", 32'(busy), 32'd0);
                chk("done_once",       32'(done), 32'd0);
                finished = 1'b1;
            end else begin
                chk("busy", 32'(busy), 32'd1);
                if (total == 0) begin
                    chk("cen_empty", 32'(sram_cen), 32'd1);
                end else if (sram_cen == 1'b0) begin
                    chk("credit", 32'((issued - accepted - int'(out_valid && out_ready)) < 2), 32'd1);
                    chk("addr", 32'(sram_addr), 32'({7'(issued / tw), 7'(issued % tw)}));
                    if (int'(sram_addr[13:7]) > max_row) max_row = int'(sram_addr[13:7]);
                    issued++;
                end
                if (out_valid && first_valid < 0) begin
                    first_valid = cyc;
                    chk("latency", 32'(cyc), 32'd3);
                end
                exp_done = (total == 0) ? (cyc == 2) : (out_valid && out_ready && accepted + 1 == total);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_pixel", 32'(accepted + 1), 32'(total));
                    end else begin
                        chk("pixel", 32'(out_val), 32'(exp_q.pop_front()));
                        last_pix = out_val;
                        accepted++;
                    end
                end
                chk("done", 32'(done), 32'(exp_done));
                if (done) done_seen = 1'b1;
                prev_stall = out_valid && !out_ready;
                prev_d     = out_val;
                if (abort_after >= 0 && accepted == abort_after) finished = 1'b1;
            end
        end
        start = 1'b0;
        if (!finished) chk("timeout", 32'(cyc), 32'd0);
        if (abort_after < 0) begin
            chk("accepted_count", 32'(accepted), 32'(total));
            chk("issued_count",   32'(issued),   32'(total));
            if (tw == 63 && th == 63) begin
                chk("last_pixel", 32'(last_pix), 32'h1E);
                chk("max_row",    32'(max_row),  32'd62);
            end
        end
    endtask

    initial begin
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_reset_values("reset");
        @(posedge CLK); #1;
        RST = 1'b1;

        run_frame(4, 3, 0, -1, 1'b0);
        run_frame(4, 3, 1, -1, 1'b0);
        run_frame(0, 5, 0, -1, 1'b0);
        run_frame(4, 3, 0, -1, 1'b1);
        run_frame(63, 63, 0, -1, 1'b0);

        // Reset in the middle of a frame, then a clean frame from pixel 0
        run_frame(4, 3, 0, 5, 1'b0);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        @(posedge CLK); #1;
        @(negedge CLK);
        check_reset_values("mid_reset");
        @(posedge CLK); #1;
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("post_reset_done",  32'(done),      32'd0);
            chk("post_reset_valid", 32'(out_valid), 32'd0);
        end
        run_frame(4, 3, 0, -1, 1'b0);

        for (int f = 0; f < 6; f++) begin
            run_frame(int'($urandom_range(1, 12)), int'($urandom_range(1, 12)), 2, -1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
